// File: rtl/spi_frame_sequencer.sv
// Sends a 0..9999 display value as a two-byte SPI frame (value/100, value%100)
// by sequencing an 8-bit SPI master: slave select, start pulses, gap and done handshake.
module spi_frame_sequencer #(
    parameter int SS_SETUP   = 4,
    parameter int GAP_CYCLES = 8,
    parameter int SS_HOLD    = 4,
    parameter int TIMEOUT    = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] value,
    input  logic        send,
    output logic        spi_start,
    output logic [7:0]  spi_tx_data,
    input  logic        spi_done,
    output logic        ssn,
    output logic        busy,
    output logic        frame_done,
    output logic        timeout_err
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_SPLIT,
        S_SS_SETUP,
        S_START_HI,
        S_WAIT_HI,
        S_GAP,
        S_START_LO,
        S_WAIT_LO,
        S_SS_HOLD
    } state_t;

    localparam logic [13:0] MAX_VAL    = 14'd9999;
    localparam logic [13:0] DIVISOR    = 14'd100;
    localparam logic [15:0] SETUP_LAST = 16'(SS_SETUP - 1);
    localparam logic [15:0] GAP_LAST   = 16'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [15:0] HOLD_LAST  = 16'(SS_HOLD - 1);
    localparam logic [31:0] WAIT_LAST  = 32'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit          TO_EN      = (TIMEOUT != 0);

    state_t      state_q;
    logic [13:0] rem_q;
    logic [6:0]  hi_q;
    logic [15:0] cnt_q;
    logic [31:0] wait_q;
    logic        spi_start_q;
    logic [7:0]  spi_tx_data_q;
    logic        ssn_q;
    logic        busy_q;
    logic        frame_done_q;
    logic        timeout_err_q;

    logic [13:0] value_sat_d;
    logic        wait_expired_d;

    always_comb begin
        value_sat_d    = (value > MAX_VAL) ? MAX_VAL : value;
        // Expiry is evaluated on the last allowed wait cycle; spi_done has priority.
        wait_expired_d = TO_EN && (wait_q == WAIT_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            rem_q         <= '0;
            hi_q          <= '0;
            cnt_q         <= '0;
            wait_q        <= '0;
            spi_start_q   <= 1'b0;
            spi_tx_data_q <= '0;
            ssn_q         <= 1'b1;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            spi_start_q   <= 1'b0;
            frame_done_q  <= 1'b0;
            timeout_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (send) begin
                        rem_q   <= value_sat_d;
                        hi_q    <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_SPLIT;
                    end
                end
                S_SPLIT: begin
                    if (rem_q >= DIVISOR) begin
                        rem_q <= rem_q - DIVISOR;
                        hi_q  <= hi_q + 7'd1;
                    end else begin
                        ssn_q   <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= S_SS_SETUP;
                    end
                end
                S_SS_SETUP: begin
                    if (cnt_q == SETUP_LAST) begin
                        spi_start_q   <= 1'b1;
                        spi_tx_data_q <= {1'b0, hi_q};
                        state_q       <= S_START_HI;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                S_START_HI: begin
                    wait_q  <= '0;
                    state_q <= S_WAIT_HI;
                end
                S_WAIT_HI: begin
                    if (spi_done) begin
                        if (GAP_CYCLES == 0) begin
                            spi_start_q   <= 1'b1;
                            spi_tx_data_q <= {1'b0, rem_q[6:0]};
                            state_q       <= S_START_LO;
                        end else begin
                            cnt_q   <= '0;
                            state_q <= S_GAP;
                        end
                    end else if (wait_expired_d) begin
                        ssn_q         <= 1'b1;
                        busy_q        <= 1'b0;
                        timeout_err_q <= 1'b1;
                        state_q       <= S_IDLE;
                    end else begin
                        wait_q <= wait_q + 32'd1;
                    end
                end
                S_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        spi_start_q   <= 1'b1;
                        spi_tx_data_q <= {1'b0, rem_q[6:0]};
                        state_q       <= S_START_LO;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                S_START_LO: begin
                    wait_q  <= '0;
                    state_q <= S_WAIT_LO;
                end
                S_WAIT_LO: begin
                    if (spi_done) begin
                        cnt_q   <= '0;
                        state_q <= S_SS_HOLD;
                    end else if (wait_expired_d) begin
                        ssn_q         <= 1'b1;
                        busy_q        <= 1'b0;
                        timeout_err_q <= 1'b1;
                        state_q       <= S_IDLE;
                    end else begin
                        wait_q <= wait_q + 32'd1;
                    end
                end
                S_SS_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        ssn_q        <= 1'b1;
                        busy_q       <= 1'b0;
                        frame_done_q <= 1'b1;
                        state_q      <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: begin
                    ssn_q   <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign spi_start   = spi_start_q;
    assign spi_tx_data = spi_tx_data_q;
    assign ssn         = ssn_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_spi_frame_sequencer.sv
// Directed bench: default-parameter instance for frame timing, TIMEOUT=16 instance for aborts.
module tb_spi_frame_sequencer;

    localparam int POST = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [13:0] value;
    logic        send;
    logic        spi_done;

    logic       a_start, a_ssn, a_busy, a_fd, a_to;
    logic [7:0] a_data;
    logic       b_start, b_ssn, b_busy, b_fd, b_to;
    logic [7:0] b_data;

    bit         sel;
    logic       o_start, o_ssn, o_busy, o_fd, o_to;
    logic [7:0] o_data;

    int n_cmp = 0;
    int n_err = 0;

    int r_fall, r_s0, r_s1, r_d0, r_d1, r_nstart, r_nfd, r_fd_at, r_nto, r_to_at;
    int r_gl, r_unstable, r_end_busy, r_end_ssn, r_hung;

    always #5 clk = ~clk;

    spi_frame_sequencer dut_a (
        .clk(clk), .reset(reset), .value(value), .send(send),
        .spi_start(a_start), .spi_tx_data(a_data), .spi_done(spi_done),
        .ssn(a_ssn), .busy(a_busy), .frame_done(a_fd), .timeout_err(a_to)
    );

    spi_frame_sequencer #(.TIMEOUT(16)) dut_b (
        .clk(clk), .reset(reset), .value(value), .send(send),
        .spi_start(b_start), .spi_tx_data(b_data), .spi_done(spi_done),
        .ssn(b_ssn), .busy(b_busy), .frame_done(b_fd), .timeout_err(b_to)
    );

    always_comb begin
        o_start = sel ? b_start : a_start;
        o_data  = sel ? b_data  : a_data;
        o_ssn   = sel ? b_ssn   : a_ssn;
        o_busy  = sel ? b_busy  : a_busy;
        o_fd    = sel ? b_fd    : a_fd;
        o_to    = sel ? b_to    : a_to;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Sends v; spi_done answers each start after dly cycles (dly<0: never).
    // A second send with xs_v is pulsed at sample xs_at (xs_at<0: none).
    task automatic run_frame(input logic [13:0] v, input int dly, input int xs_at,
                             input logic [13:0] xs_v);
        int pend = -1;
        int cur_data = 0;
        bit ended = 1'b0;
        int post = 0;
        r_fall = -1; r_s0 = -1; r_s1 = -1; r_d0 = -1; r_d1 = -1;
        r_nstart = 0; r_nfd = 0; r_fd_at = -1; r_nto = 0; r_to_at = -1;
        r_gl = 0; r_unstable = 0; r_end_busy = -1; r_end_ssn = -1; r_hung = 0;
        value = v;
        send  = 1'b1;
        tick();
        for (int n = 0; n < 600; n++) begin
            send     = 1'b0;
            spi_done = 1'b0;
            if (o_start) begin
                if (r_nstart == 0) begin r_s0 = n; r_d0 = int'(o_data); end
                if (r_nstart == 1) begin r_s1 = n; r_d1 = int'(o_data); end
                cur_data = int'(o_data);
                r_nstart++;
                if (dly >= 0) pend = n + dly;
            end
            if (r_nstart > 0 && pend >= n && int'(o_data) != cur_data) r_unstable++;
            if (pend == n) spi_done = 1'b1;
            if (r_fall < 0 && !o_ssn) r_fall = n;
            if (r_fall >= 0 && !ended && o_ssn && !(o_fd || o_to)) r_gl++;
            if (o_fd) begin r_nfd++; if (!ended) r_fd_at = n; end
            if (o_to) begin r_nto++; if (!ended) r_to_at = n; end
            if (n == xs_at) begin send = 1'b1; value = xs_v; end
            if ((o_fd || o_to) && !ended) begin
                ended      = 1'b1;
                r_end_busy = int'(o_busy);
                r_end_ssn  = int'(o_ssn);
            end
            if (ended) post++;
            if (post > POST) break;
            tick();
        end
        send     = 1'b0;
        spi_done = 1'b0;
        if (!ended) r_hung = 1;
    endtask

    task automatic check_frame(input string p, input int fall, input int s0, input int d0,
                               input int s1, input int d1, input int fd);
        chk({p, ".hung"}, r_hung, 0);
        chk({p, ".ssn_fall"}, r_fall, fall);
        chk({p, ".start_hi_at"}, r_s0, s0);
        chk({p, ".byte_hi"}, r_d0, d0);
        chk({p, ".start_lo_at"}, r_s1, s1);
        chk({p, ".byte_lo"}, r_d1, d1);
        chk({p, ".n_start"}, r_nstart, 2);
        chk({p, ".frame_done_at"}, r_fd_at, fd);
        chk({p, ".n_frame_done"}, r_nfd, 1);
        chk({p, ".n_timeout"}, r_nto, 0);
        chk({p, ".ssn_glitch"}, r_gl, 0);
        chk({p, ".tx_unstable"}, r_unstable, 0);
        chk({p, ".end_busy"}, r_end_busy, 0);
        chk({p, ".end_ssn"}, r_end_ssn, 1);
    endtask

    initial begin
        int stray;
        sel      = 1'b0;
        reset    = 1'b1;
        value    = '0;
        send     = 1'b0;
        spi_done = 1'b0;
        tick();
        tick();
        chk("rst.ssn", int'(a_ssn), 1);
        chk("rst.start", int'(a_start), 0);
        chk("rst.data", int'(a_data), 0);
        chk("rst.busy", int'(a_busy), 0);
        chk("rst.frame_done", int'(a_fd), 0);
        chk("rst.timeout_err", int'(a_to), 0);
        reset = 1'b0;
        tick();

        // Sample n is the state after edge n; send is taken at edge 0.
        // hi start = hi+1+4, lo start = hi start+20+8+1, frame_done = lo start+20+4+1
        run_frame(14'd1234, 20, -1, 14'd0);
        check_frame("v1234", 13, 17, 8'h0C, 46, 8'h22, 71);
        tick();
        run_frame(14'd0, 20, -1, 14'd0);
        check_frame("v0", 1, 5, 8'h00, 34, 8'h00, 59);
        tick();
        run_frame(14'd9999, 20, -1, 14'd0);
        check_frame("v9999", 100, 104, 8'h63, 133, 8'h63, 158);
        tick();
        run_frame(14'd12000, 20, -1, 14'd0);
        check_frame("v12000", 100, 104, 8'h63, 133, 8'h63, 158);
        tick();
        run_frame(14'd1234, 20, 25, 14'd42);
        check_frame("busy_send", 13, 17, 8'h0C, 46, 8'h22, 71);
        tick();

        // Reset in the GAP: hi done seen in cycle 37, GAP spans samples 38..45.
        value = 14'd1234;
        send  = 1'b1;
        tick();
        send = 1'b0;
        for (int n = 0; n <= 40; n++) begin
            if (n == 17) chk("rst_mid.start_hi", int'(a_start), 1);
            spi_done = (n == 37);
            if (n == 40) begin
                chk("rst_mid.in_gap_ssn", int'(a_ssn), 0);
                chk("rst_mid.in_gap_busy", int'(a_busy), 1);
                reset    = 1'b1;
                spi_done = 1'b0;
            end
            tick();
        end
        chk("rst_mid.ssn", int'(a_ssn), 1);
        chk("rst_mid.busy", int'(a_busy), 0);
        chk("rst_mid.start", int'(a_start), 0);
        chk("rst_mid.frame_done", int'(a_fd), 0);
        chk("rst_mid.timeout_err", int'(a_to), 0);
        reset = 1'b0;
        tick();
        spi_done = 1'b1;
        tick();
        spi_done = 1'b0;
        stray = 0;
        for (int n = 0; n < 10; n++) begin
            if (a_start || !a_ssn || a_busy || a_fd || a_to) stray++;
            tick();
        end
        chk("rst_mid.stray_done", stray, 0);

        // TIMEOUT=16: value 500 -> hi 5, start at 10, WAIT_HI samples 11..26, abort at 27.
        sel = 1'b1;
        run_frame(14'd500, -1, -1, 14'd0);
        chk("to.hung", r_hung, 0);
        chk("to.start_hi_at", r_s0, 10);
        chk("to.byte_hi", r_d0, 8'h05);
        chk("to.n_start", r_nstart, 1);
        chk("to.timeout_at", r_to_at, 27);
        chk("to.n_timeout", r_nto, 1);
        chk("to.n_frame_done", r_nfd, 0);
        chk("to.end_ssn", r_end_ssn, 1);
        chk("to.end_busy", r_end_busy, 0);
        tick();
        // Next frame on the same instance, done after 5: 17, 17+5+9=31, 31+5+5=41.
        run_frame(14'd1234, 5, -1, 14'd0);
        check_frame("to_next", 13, 17, 8'h0C, 31, 8'h22, 41);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
